// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 5;
   localparam logic [REG_IDX_W-1:0] ZERO_REG = REG_IDX_W'(0);

   // Data-cache handshake state
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } hsc_state_e;

   // A load in EX whose destination feeds either source of the instruction in ID
   function automatic logic load_use(input logic                 mem_read,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs1,
                                     input logic [REG_IDX_W-1:0] rs2);
      return mem_read && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a freeze input.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         hold_i,
   output logic [W-1:0] cnt_o
);

   // Count qualifying edges, stick at all-ones, ignore events while held
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         cnt_o <= '0;
      else if (inc_i && !hold_i && (cnt_o != {W{1'b1}}))
         cnt_o <= cnt_o + W'(1);
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-pipeline stall/flush sequencer: load-use, taken branch and data-cache miss.
module hazard_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ID_EX_MemRead_i,
   input  logic [REG_IDX_W-1:0] ID_EX_Rd_i,
   input  logic [REG_IDX_W-1:0] IF_ID_Rs1_i,
   input  logic [REG_IDX_W-1:0] IF_ID_Rs2_i,
   input  logic                 Branch_Taken_i,
   input  logic                 DCache_Req_i,
   input  logic                 DCache_Ack_i,
   output logic                 PC_Write_o,
   output logic                 IF_ID_Write_o,
   output logic                 IF_ID_Flush_o,
   output logic                 ID_EX_Bubble_o,
   output logic                 MemStall_o,
   output logic                 Err_o,
   output logic [CNT_W-1:0]     Stall_Cnt_o,
   output logic [CNT_W-1:0]     Bubble_Cnt_o,
   output logic [CNT_W-1:0]     Flush_Cnt_o
);

   localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   hsc_state_e      state;
   logic [TO_W-1:0] to_cnt;
   logic            lu;
   logic            mem_stall;
   logic            in_err;

   // Cache handshake FSM with watchdog; error flag is sticky until reset
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state  <= IDLE;
         to_cnt <= '0;
         Err_o  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (DCache_Req_i && !DCache_Ack_i) begin
                  state  <= WAIT;
                  to_cnt <= '0;
               end
            end
            WAIT: begin
               if (DCache_Ack_i) begin
                  state <= IDLE;
               end else if (to_cnt == TO_LAST) begin
                  state <= ERR;
                  Err_o <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ERR:     state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

   // Hazard resolution: freeze beats load-use bubble beats branch flush
   always_comb begin
      lu             = load_use(ID_EX_MemRead_i, ID_EX_Rd_i, IF_ID_Rs1_i, IF_ID_Rs2_i);
      mem_stall      = rst_i && ((state == ERR) ||
                                 ((state == WAIT) && !DCache_Ack_i) ||
                                 ((state == IDLE) && DCache_Req_i && !DCache_Ack_i));
      PC_Write_o     = 1'b1;
      IF_ID_Write_o  = 1'b1;
      IF_ID_Flush_o  = 1'b0;
      ID_EX_Bubble_o = 1'b0;
      if (mem_stall) begin
         PC_Write_o    = 1'b0;
         IF_ID_Write_o = 1'b0;
      end else if (lu) begin
         PC_Write_o     = 1'b0;
         IF_ID_Write_o  = 1'b0;
         ID_EX_Bubble_o = 1'b1;
      end else if (Branch_Taken_i) begin
         IF_ID_Flush_o = 1'b1;
      end
   end

   assign MemStall_o = mem_stall;
   assign in_err     = (state == ERR);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (mem_stall),
      .hold_i (in_err),
      .cnt_o  (Stall_Cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (ID_EX_Bubble_o),
      .hold_i (in_err),
      .cnt_o  (Bubble_Cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (IF_ID_Flush_o),
      .hold_i (in_err),
      .cnt_o  (Flush_Cnt_o)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl with a cycle-level reference model.
module tb_hazard_stall_ctrl;

   localparam int unsigned TIMEOUT = 8;
   localparam int unsigned CNT_W   = 4;
   localparam int          MAXC    = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             ID_EX_MemRead_i;
   logic [4:0]       ID_EX_Rd_i, IF_ID_Rs1_i, IF_ID_Rs2_i;
   logic             Branch_Taken_i, DCache_Req_i, DCache_Ack_i;
   logic             PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o;
   logic             MemStall_o, Err_o;
   logic [CNT_W-1:0] Stall_Cnt_o, Bubble_Cnt_o, Flush_Cnt_o;

   int tests = 0;
   int fails = 0;

   // Reference model: outstanding miss, cycles already waited, sticky error, event totals
   bit m_miss;
   int m_waited;
   bit m_err;
   int m_stall, m_bubble, m_flush;

   hazard_stall_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .ID_EX_MemRead_i (ID_EX_MemRead_i),
      .ID_EX_Rd_i      (ID_EX_Rd_i),
      .IF_ID_Rs1_i     (IF_ID_Rs1_i),
      .IF_ID_Rs2_i     (IF_ID_Rs2_i),
      .Branch_Taken_i  (Branch_Taken_i),
      .DCache_Req_i    (DCache_Req_i),
      .DCache_Ack_i    (DCache_Ack_i),
      .PC_Write_o      (PC_Write_o),
      .IF_ID_Write_o   (IF_ID_Write_o),
      .IF_ID_Flush_o   (IF_ID_Flush_o),
      .ID_EX_Bubble_o  (ID_EX_Bubble_o),
      .MemStall_o      (MemStall_o),
      .Err_o           (Err_o),
      .Stall_Cnt_o     (Stall_Cnt_o),
      .Bubble_Cnt_o    (Bubble_Cnt_o),
      .Flush_Cnt_o     (Flush_Cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int sat_inc(input int v, input bit ev);
      return (ev && v < MAXC) ? v + 1 : v;
   endfunction

   task automatic model_clear();
      m_miss = 0; m_waited = 0; m_err = 0;
      m_stall = 0; m_bubble = 0; m_flush = 0;
   endtask

   // One clock: drive, check all outputs mid-cycle against the model, advance the model
   task automatic do_cycle(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input bit br, input bit req, input bit ack);
      bit lu, stall, bub, fl;
      ID_EX_MemRead_i = mr;  ID_EX_Rd_i = rd;  IF_ID_Rs1_i = rs1;  IF_ID_Rs2_i = rs2;
      Branch_Taken_i  = br;  DCache_Req_i = req;  DCache_Ack_i = ack;
      @(negedge clk_i);
      lu    = mr && rd != 0 && (rd == rs1 || rd == rs2);
      stall = m_err || (m_miss ? !ack : (req && !ack));
      bub   = !stall && lu;
      fl    = !stall && !lu && br;
      chk("mem_stall",  MemStall_o,     stall);
      chk("pc_write",   PC_Write_o,     !(stall || lu));
      chk("ifid_write", IF_ID_Write_o,  !(stall || lu));
      chk("ifid_flush", IF_ID_Flush_o,  fl);
      chk("bubble",     ID_EX_Bubble_o, bub);
      chk("err",        Err_o,          m_err);
      chk("stall_cnt",  Stall_Cnt_o,    m_stall);
      chk("bubble_cnt", Bubble_Cnt_o,   m_bubble);
      chk("flush_cnt",  Flush_Cnt_o,    m_flush);
      if (!m_err) begin
         m_stall  = sat_inc(m_stall, stall);
         m_bubble = sat_inc(m_bubble, bub);
         m_flush  = sat_inc(m_flush, fl);
         if (m_miss) begin
            if (ack) m_miss = 0;
            else if (m_waited == TIMEOUT - 1) begin m_err = 1; m_miss = 0; end
            else m_waited++;
         end else if (req && !ack) begin
            m_miss = 1; m_waited = 0;
         end
      end
      @(posedge clk_i); #1;
   endtask

   // Asynchronous reset asserted mid-cycle with a request still pending
   task automatic do_reset();
      ID_EX_MemRead_i = 0; Branch_Taken_i = 0;
      rst_i = 1'b0;
      #1;
      model_clear();
      chk("rst_mem_stall", MemStall_o,   1'b0);
      chk("rst_err",       Err_o,        1'b0);
      chk("rst_pc_write",  PC_Write_o,   1'b1);
      chk("rst_stall_cnt", Stall_Cnt_o,  0);
      chk("rst_flush_cnt", Flush_Cnt_o,  0);
      DCache_Req_i = 0; DCache_Ack_i = 0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   initial begin
      bit req, ack;
      rst_i = 1'b0;
      ID_EX_MemRead_i = 0; ID_EX_Rd_i = 0; IF_ID_Rs1_i = 0; IF_ID_Rs2_i = 0;
      Branch_Taken_i = 0; DCache_Req_i = 1; DCache_Ack_i = 0;
      model_clear();
      #12;
      chk("init_mem_stall", MemStall_o,    1'b0);
      chk("init_ifid_wr",   IF_ID_Write_o, 1'b1);
      chk("init_bub_cnt",   Bubble_Cnt_o,  0);
      DCache_Req_i = 0;
      @(negedge clk_i); rst_i = 1'b1;
      @(posedge clk_i); #1;

      // Load-use with rd=5 bubbles; rd=0 never does
      do_cycle(1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      chk("lu_bubble_cnt", Bubble_Cnt_o, 1);
      do_cycle(1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      chk("lu_x0_bubble_cnt", Bubble_Cnt_o, 1);

      // Branch taken, no hazards
      do_cycle(0, 5'd0, 5'd0, 5'd0, 1, 0, 0);
      chk("br_flush_cnt", Flush_Cnt_o, 1);

      // Three-cycle miss with branch held; flush lands on the ack cycle
      repeat (3) do_cycle(0, 5'd0, 5'd0, 5'd0, 1, 1, 0);
      do_cycle(0, 5'd0, 5'd0, 5'd0, 1, 1, 1);
      chk("miss_stall_cnt", Stall_Cnt_o, 3);
      chk("miss_flush_cnt", Flush_Cnt_o, 2);

      // Single-cycle hit
      do_cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
      chk("hit_stall_cnt", Stall_Cnt_o, 3);

      // Watchdog expiry: request cycle plus TIMEOUT waiting cycles
      repeat (TIMEOUT + 1) do_cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      chk("wd_err", Err_o, 1'b1);
      repeat (2) do_cycle(1, 5'd3, 5'd3, 5'd3, 1, 1, 0);
      chk("wd_stuck_stall", MemStall_o, 1'b1);
      chk("wd_frozen_cnt", Stall_Cnt_o, 12);
      do_reset();

      // Ack on the last permitted waiting cycle wins over the watchdog
      repeat (TIMEOUT) do_cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      do_cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
      chk("wd_late_ack_err", Err_o, 1'b0);

      // Bubble counter saturation
      repeat (20) do_cycle(1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
      chk("sat_bubble_cnt", Bubble_Cnt_o, 15);

      // Randomized traffic obeying the hold-request-until-ack protocol
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (m_err || (i % 80 == 79)) do_reset();
         req = m_miss ? 1'b1 : ($urandom_range(0, 3) == 0);
         ack = req && ($urandom_range(0, 2) == 0);
         do_cycle($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, req, ack);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
